clk_div_monitor: RTL

- Checker for divided clocks. Samples a divided clock in the source `clk` domain and measures its period and high time in `clk` cycles.
- Declares lock once the divider output matches the expected ratio, and flags errors when it does not.
- Sits next to the divide-by-N clock generators as a self-check. It is the consuming end of the divider output, and its status is readable by software or a bench.

---
 rtl/clk_div_monitor.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/clk_div_monitor.sv
// -----------------------------------------------------------------------------
// clk_div_monitor
//
// Self-check for a divide-by-N clock generator. The divided clock is sampled
// as data in the source clock domain. The block measures its period and high
// time in clk cycles, declares lock after LOCK_CNT consecutive good periods,
// and flags bad periods, bad high times and missing edges.
//
// Build option:
//   CLK_DIV_MON_SYNC_EN - when defined, clk_div goes through a 2-flop
//                         synchronizer before sampling. This is for dividers
//                         that are not generated from clk. All status outputs
//                         then lag by 2 cycles. Measured values do not change.
//
// Ports:
//   clk        in   source clock; all logic is in this domain
//   rst        in   asynchronous reset, active low
//   clk_div    in   divided clock under test, sampled as data
//   clear      in   sync pulse: err_cnt=0, lock dropped, FSM back to IDLE
//   period     out  last measured period (clk cycles)
//   high_time  out  last measured high time (clk cycles)
//   meas_vld   out  1-cycle pulse when period/high_time update
//   locked     out  ratio confirmed over LOCK_CNT consecutive periods
//   err        out  1-cycle pulse: bad measurement or timeout
//   timeout    out  sticky: no rise within 2*EXP_RATIO cycles
//   err_cnt    out  saturating count of err pulses
// -----------------------------------------------------------------------------
module clk_div_monitor #(
  parameter int EXP_RATIO = 4,
  parameter int CNT_W     = 8,
  parameter int LOCK_CNT  = 4,
  parameter int ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_div,
  input  logic             clear,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_vld,
  output logic             locked,
  output logic             err,
  output logic             timeout,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_LOCKED} state_t;

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] EXP_C   = CNT_W'(EXP_RATIO);
  localparam logic [CNT_W-1:0] TMO_C   = CNT_W'(2 * EXP_RATIO);
  localparam logic [CNT_W-1:0] HI_LO_C = CNT_W'(EXP_RATIO / 2);
  localparam logic [CNT_W-1:0] HI_HI_C = CNT_W'((EXP_RATIO + 1) / 2);
  localparam logic [GW-1:0]    LOCK_C  = GW'(LOCK_CNT);
  localparam logic [GW-1:0]    LOCK_M1 = GW'(LOCK_CNT - 1);

  state_t           state;
  logic             s, s_q;
  logic [CNT_W-1:0] per_cnt, hi_cnt, hi_fall;
  logic [GW-1:0]    good_cnt;

  // ---------------------------------------------------------------------------
  // Sampling of the divided clock
  // ---------------------------------------------------------------------------
`ifdef CLK_DIV_MON_SYNC_EN
  logic [1:0] sync_ff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_ff <= '0;
      s       <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], clk_div};
      s       <= sync_ff[1];
      s_q     <= s;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s   <= 1'b0;
      s_q <= 1'b0;
    end else begin
      s   <= clk_div;
      s_q <= s;
    end
  end
`endif

  logic rise, fall;
  assign rise = s & ~s_q;
  assign fall = ~s & s_q;

  // Saturating increments. Counters stop at all-ones so that a stuck input
  // cannot wrap back into a value that looks good.
  logic [CNT_W-1:0] per_inc, hi_inc;
  logic [ERR_W-1:0] err_inc;
  assign per_inc = (per_cnt == '1) ? per_cnt : per_cnt + 1'b1;
  assign hi_inc  = (hi_cnt  == '1) ? hi_cnt  : hi_cnt  + 1'b1;
  assign err_inc = (err_cnt == '1) ? err_cnt : err_cnt + 1'b1;

  // per_cnt already holds the period when a rise is seen, because it is
  // restarted at 1 on the previous rise. The high time comes from the
  // capture taken at the fall inside this period.
  logic meas_good;
  assign meas_good = (per_cnt == EXP_C) && ((hi_fall == HI_LO_C) || (hi_fall == HI_HI_C));

  // ---------------------------------------------------------------------------
  // Measurement FSM with registered status outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      per_cnt   <= '0;
      hi_cnt    <= '0;
      hi_fall   <= '0;
      good_cnt  <= '0;
      period    <= '0;
      high_time <= '0;
      meas_vld  <= 1'b0;
      locked    <= 1'b0;
      err       <= 1'b0;
      timeout   <= 1'b0;
      err_cnt   <= '0;
    end else begin
      meas_vld <= 1'b0;
      err      <= 1'b0;
      if (fall) hi_fall <= hi_cnt;

      if (clear) begin
        // Overrides any same-cycle rise or timeout. Last measurement is kept.
        state    <= S_IDLE;
        per_cnt  <= '0;
        hi_cnt   <= '0;
        good_cnt <= '0;
        locked   <= 1'b0;
        timeout  <= 1'b0;
        err_cnt  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            per_cnt <= '0;
            hi_cnt  <= '0;
            // First rise only sets the reference point. No measurement exists yet.
            if (rise) begin
              state    <= S_MEASURE;
              per_cnt  <= CNT_W'(1);
              hi_cnt   <= CNT_W'(1);
              good_cnt <= '0;
              timeout  <= 1'b0;
            end
          end
          default: begin
            per_cnt <= per_inc;
            if (s) hi_cnt <= hi_inc;
            if (rise) begin
              per_cnt   <= CNT_W'(1);
              hi_cnt    <= CNT_W'(1);
              period    <= per_cnt;
              high_time <= hi_fall;
              meas_vld  <= 1'b1;
              if (meas_good) begin
                if (state != S_LOCKED) begin
                  if (good_cnt == LOCK_M1) begin
                    state    <= S_LOCKED;
                    locked   <= 1'b1;
                    good_cnt <= LOCK_C;
                  end else begin
                    good_cnt <= good_cnt + 1'b1;
                  end
                end
              end else begin
                state    <= S_MEASURE;
                locked   <= 1'b0;
                good_cnt <= '0;
                err      <= 1'b1;
                err_cnt  <= err_inc;
              end
            end else if (per_cnt == TMO_C) begin
              // Leaving to IDLE stops the counter, so this fires once per event.
              state    <= S_IDLE;
              per_cnt  <= '0;
              hi_cnt   <= '0;
              good_cnt <= '0;
              locked   <= 1'b0;
              timeout  <= 1'b1;
              err      <= 1'b1;
              err_cnt  <= err_inc;
            end
          end
        endcase
      end
    end
  end

endmodule
